ps2_zx_keymatrix: RTL

- Translates the raw PS/2 set-2 byte stream from the ps2 receiver into the 8x5 ZX Spectrum keyboard matrix, which main samples on ULA port reads.
- Also produces the hot-key flags that drive NMI and reset generation: F5, F12, Ctrl, Alt, Del and Scroll Lock.
- Sits between the ps2 receiver and main.
- Parses the E0 (extended), F0 (break) and E1 (Pause) prefixes itself.
- Expands PC-only keys into ZX key combinations.

---
 rtl/ps2_zx_keymatrix.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_zx_keymatrix.sv
// PS/2 set-2 byte stream to ZX Spectrum 8x5 keyboard matrix.
// Also tracks hot-key flags used for NMI and reset generation.
module ps2_zx_keymatrix #(
  parameter bit EXTKEYS  = 1'b1,
  parameter int PAUSELEN = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kstb,
  input  logic [7:0] code,
  input  logic [7:0] a,
  output logic [4:0] q,
  output logic       f5,
  output logic       f12,
  output logic       ctrl,
  output logic       alt,
  output logic       del,
  output logic       scrlck
);

  localparam int CW = (PAUSELEN < 2) ? 1 : $clog2(PAUSELEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK,
    S_PAUSE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [40:0]   keys_q, keys_d;
  logic [4:0]    comp_q, comp_d;
  logic [8:0]    flg_q, flg_d;
  logic [4:0]    q_q, q_d;
  logic          plain_ev, ext_ev, clr_ev, val;
  logic          dir_hit;
  logic [5:0]    dir_idx;
  logic [39:0]   prs;

  // Bit index is row*5+col; bit 40 is right shift, folded into CS.
  function automatic logic [6:0] dmap(input logic [7:0] c);
    logic [6:0] r;
    r = 7'd0;
    case (c)
      8'h12: r = {1'b1, 6'd0};
      8'h1A: r = {1'b1, 6'd1};
      8'h22: r = {1'b1, 6'd2};
      8'h21: r = {1'b1, 6'd3};
      8'h2A: r = {1'b1, 6'd4};
      8'h1C: r = {1'b1, 6'd5};
      8'h1B: r = {1'b1, 6'd6};
      8'h23: r = {1'b1, 6'd7};
      8'h2B: r = {1'b1, 6'd8};
      8'h34: r = {1'b1, 6'd9};
      8'h15: r = {1'b1, 6'd10};
      8'h1D: r = {1'b1, 6'd11};
      8'h24: r = {1'b1, 6'd12};
      8'h2D: r = {1'b1, 6'd13};
      8'h2C: r = {1'b1, 6'd14};
      8'h16: r = {1'b1, 6'd15};
      8'h1E: r = {1'b1, 6'd16};
      8'h26: r = {1'b1, 6'd17};
      8'h25: r = {1'b1, 6'd18};
      8'h2E: r = {1'b1, 6'd19};
      8'h45: r = {1'b1, 6'd20};
      8'h46: r = {1'b1, 6'd21};
      8'h3E: r = {1'b1, 6'd22};
      8'h3D: r = {1'b1, 6'd23};
      8'h36: r = {1'b1, 6'd24};
      8'h4D: r = {1'b1, 6'd25};
      8'h44: r = {1'b1, 6'd26};
      8'h43: r = {1'b1, 6'd27};
      8'h3C: r = {1'b1, 6'd28};
      8'h35: r = {1'b1, 6'd29};
      8'h5A: r = {1'b1, 6'd30};
      8'h4B: r = {1'b1, 6'd31};
      8'h42: r = {1'b1, 6'd32};
      8'h3B: r = {1'b1, 6'd33};
      8'h33: r = {1'b1, 6'd34};
      8'h29: r = {1'b1, 6'd35};
      8'h14: r = {1'b1, 6'd36};
      8'h3A: r = {1'b1, 6'd37};
      8'h31: r = {1'b1, 6'd38};
      8'h32: r = {1'b1, 6'd39};
      8'h59: r = {1'b1, 6'd40};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  always_comb {dir_hit, dir_idx} = dmap(code);

  always_comb begin
    plain_ev = 1'b0;
    ext_ev   = 1'b0;
    clr_ev   = 1'b0;
    val      = 1'b0;
    if (kstb) begin
      unique case (state_q)
        S_IDLE: begin
          clr_ev   = (code == 8'hAA);
          plain_ev = !(code inside {8'hE0, 8'hF0, 8'hE1, 8'hAA});
          val      = 1'b1;
        end
        S_EXT: begin
          ext_ev = (code != 8'hF0);
          val    = 1'b1;
        end
        S_BRK:    plain_ev = 1'b1;
        S_EXTBRK: ext_ev   = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    keys_d = keys_q;
    comp_d = comp_q;
    flg_d  = flg_q;
    if (clr_ev) begin
      keys_d = '0;
      comp_d = '0;
      flg_d  = '0;
    end else if (plain_ev) begin
      if (dir_hit) keys_d[dir_idx] = val;
      case (code)
        8'h66: comp_d[0] = val;
        8'h03: flg_d[0]  = val;
        8'h07: flg_d[1]  = val;
        8'h14: flg_d[2]  = val;
        8'h11: flg_d[4]  = val;
        8'h71: flg_d[6]  = val;
        8'h7E: flg_d[8]  = val;
        default: ;
      endcase
    end else if (ext_ev) begin
      case (code)
        8'h14: flg_d[3] = val;
        8'h11: flg_d[5] = val;
        8'h71: flg_d[7] = val;
        8'h6B: if (EXTKEYS) comp_d[1] = val;
        8'h72: if (EXTKEYS) comp_d[2] = val;
        8'h75: if (EXTKEYS) comp_d[3] = val;
        8'h74: if (EXTKEYS) comp_d[4] = val;
        default: ;
      endcase
    end
  end

  // Each composite owns its flag, so shared keys are ORed, not overwritten.
  always_comb begin
    prs     = keys_q[39:0];
    prs[0]  = keys_q[0] | keys_q[40] | (|comp_q);
    prs[20] = keys_q[20] | comp_q[0];
    prs[19] = keys_q[19] | comp_q[1];
    prs[24] = keys_q[24] | comp_q[2];
    prs[23] = keys_q[23] | comp_q[3];
    prs[22] = keys_q[22] | comp_q[4];
  end

  always_comb begin
    logic [4:0] acc;
    acc = 5'd0;
    for (int r = 0; r < 8; r++) begin
      if (!a[r]) acc = acc | prs[r*5 +: 5];
    end
    q_d = ~acc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      keys_q  <= '0;
      comp_q  <= '0;
      flg_q   <= '0;
      q_q     <= 5'h1F;
    end else begin
      keys_q <= keys_d;
      comp_q <= comp_d;
      flg_q  <= flg_d;
      q_q    <= q_d;
      if (kstb) begin
        unique case (state_q)
          S_IDLE: begin
            if (code == 8'hE0) begin
              state_q <= S_EXT;
            end else if (code == 8'hF0) begin
              state_q <= S_BRK;
            end else if (code == 8'hE1 && PAUSELEN > 0) begin
              state_q <= S_PAUSE;
              cnt_q   <= CW'(PAUSELEN);
            end
          end
          S_EXT: begin
            state_q <= (code == 8'hF0) ? S_EXTBRK : S_IDLE;
          end
          S_BRK, S_EXTBRK: state_q <= S_IDLE;
          S_PAUSE: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q <= CW'(1)) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign q      = q_q;
  assign f5     = ~flg_q[0];
  assign f12    = ~flg_q[1];
  assign ctrl   = ~(flg_q[2] | flg_q[3]);
  assign alt    = ~(flg_q[4] | flg_q[5]);
  assign del    = ~(flg_q[6] | flg_q[7]);
  assign scrlck = ~flg_q[8];

endmodule
